// File: rtl/spi_dev_pw_arbiter_pkg.sv
// Shared definitions for the SPI device protocol-wrapper arbiter: FSM states,
// reserved command codes and the command index field.
package spi_dev_pw_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_GRANT = 2'd2,
        ST_REL   = 2'd3
    } arb_state_t;

    typedef logic [3:0] ep_idx_t;

    localparam logic [7:0] CMD_NOP      = 8'hff;
    localparam logic [7:0] CMD_RESP_ACK = 8'hfe;
    localparam int         CMD_IDX_MSB  = 7;
    localparam int         CMD_IDX_LSB  = 4;

    function automatic ep_idx_t cmd_index(input logic [7:0] cmd);
        return cmd[CMD_IDX_MSB:CMD_IDX_LSB];
    endfunction

endpackage

// File: rtl/spi_dev_pw_arbiter_if.sv
// Protocol-wrapper side of the arbiter: write stream, response channel, IRQ status.
interface spi_dev_pw_arbiter_if;
    logic [7:0] pw_wdata;
    logic       pw_wcmd;
    logic       pw_wstb;
    logic       pw_end;
    logic       pw_req;
    logic       pw_gnt;
    logic [7:0] pw_rdata;
    logic       pw_rstb;
    logic [3:0] pw_irq;

    modport master (
        output pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_gnt,
        input  pw_req, pw_rdata, pw_rstb, pw_irq
    );

    modport slave (
        input  pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_gnt,
        output pw_req, pw_rdata, pw_rstb, pw_irq
    );
endinterface

// File: rtl/spi_dev_pw_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping at N. Returns the winner as one-hot and as an index.
module rr_pick
    import spi_dev_pw_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  ep_idx_t      ptr,
    output logic [N-1:0] onehot,
    output ep_idx_t      idx,
    output logic         valid
);

    // NOTE: every output gets a default before the loop so no path can leave
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        int c;
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        c      = 0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!valid && req[c]) begin
                valid     = 1'b1;
                onehot[c] = 1'b1;
                idx       = ep_idx_t'(c);
            end
        end
    end

endmodule

// File: rtl/spi_dev_pw_arbiter.sv
// Routes SPI write streams to endpoints by command index, arbitrates endpoint
// responses round-robin onto one channel, folds IRQs. Optional: PW_ARB_TIMEOUT_EN.
module spi_dev_pw_arbiter
    import spi_dev_pw_arbiter_pkg::*;
#(
    parameter int N_EP     = 4,
    parameter int MAX_RESP = 256,
    parameter int TIMEOUT  = 4096
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_dev_pw_arbiter_if.slave pw,
    output logic [7:0]          ep_wdata,
    output logic                ep_wcmd,
    output logic [N_EP-1:0]     ep_wstb,
    output logic [N_EP-1:0]     ep_end,
    input  logic [N_EP-1:0]     ep_req,
    output logic [N_EP-1:0]     ep_gnt,
    input  logic [8*N_EP-1:0]   ep_rdata,
    input  logic [N_EP-1:0]     ep_rstb,
    input  logic [N_EP-1:0]     ep_irq,
    output logic                err_ovf,
    output logic                err_tmo
);

    localparam logic [8:0] MAX_CNT = 9'(MAX_RESP);
    localparam ep_idx_t    LAST_EP = ep_idx_t'(N_EP - 1);

    // ---------------- write routing ----------------
    ep_idx_t cmd_idx, route;
    logic    route_vld, cmd_stb, cmd_routed;

    assign ep_wdata   = pw.pw_wdata;
    assign ep_wcmd    = pw.pw_wcmd;
    assign cmd_idx    = cmd_index(pw.pw_wdata);
    assign cmd_stb    = pw.pw_wstb & pw.pw_wcmd;
    assign cmd_routed = (cmd_idx <= LAST_EP) &&
                        (pw.pw_wdata != CMD_NOP) && (pw.pw_wdata != CMD_RESP_ACK);

    always_comb begin
        ep_wstb = '0;
        ep_end  = '0;
        for (int i = 0; i < N_EP; i++) begin
            if (cmd_stb)
                ep_wstb[i] = cmd_routed && (cmd_idx == ep_idx_t'(i));
            else if (pw.pw_wstb)
                ep_wstb[i] = route_vld && (route == ep_idx_t'(i));
            ep_end[i] = pw.pw_end && route_vld && (route == ep_idx_t'(i));
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            route_vld <= 1'b0;
            route     <= '0;
        end else if (pw.pw_end) begin
            route_vld <= 1'b0;
        end else if (cmd_stb) begin
            route_vld <= cmd_routed;
            route     <= cmd_idx;
        end
    end

    // ---------------- response arbiter ----------------
    arb_state_t      state, state_nxt;
    ep_idx_t         sel, rr, pick_idx;
    logic [N_EP-1:0] sel_oh, pick_oh;
    logic            pick_vld, sel_req, sel_stb, tmo_hit;
    logic [7:0]      sel_data;
    logic [8:0]      cnt;
    logic            req_c, rstb_c;
    logic [7:0]      rdata_c;

    rr_pick #(.N(N_EP)) u_pick (
        .req    (ep_req),
        .ptr    (rr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .valid  (pick_vld)
    );

    assign sel_req = |(ep_req & sel_oh);
    assign sel_stb = |(ep_rstb & sel_oh);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_EP; i++)
            if (sel_oh[i]) sel_data = ep_rdata[8*i +: 8];
    end

    always_comb begin
        state_nxt = state;
        req_c     = 1'b0;
        rstb_c    = 1'b0;
        rdata_c   = '0;
        ep_gnt    = '0;
        case (state)
            ST_IDLE: if (pick_vld) state_nxt = ST_REQ;
            ST_REQ: begin
                req_c = 1'b1;
                if (tmo_hit)        state_nxt = ST_REL;
                else if (pw.pw_gnt) state_nxt = ST_GRANT;
            end
            ST_GRANT: begin
                req_c   = 1'b1;
                ep_gnt  = sel_oh;
                rdata_c = sel_data;
                rstb_c  = sel_stb && (cnt < MAX_CNT);
                if (tmo_hit || !sel_req || !pw.pw_gnt) state_nxt = ST_REL;
            end
            ST_REL:  if (!pw.pw_gnt) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign pw.pw_req   = req_c;
    assign pw.pw_rstb  = rstb_c;
    assign pw.pw_rdata = rdata_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            sel     <= '0;
            sel_oh  <= '0;
            rr      <= '0;
            cnt     <= '0;
            err_ovf <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && pick_vld) begin
                sel    <= pick_idx;
                sel_oh <= pick_oh;
            end
            // Bytes past the per-grant limit are dropped and flagged, never forwarded.
            if (state == ST_GRANT && sel_stb) begin
                if (cnt < MAX_CNT) cnt <= cnt + 9'd1;
                else               err_ovf <= 1'b1;
            end
            if (state == ST_REL && !pw.pw_gnt) begin
                rr  <= (sel == LAST_EP) ? '0 : sel + ep_idx_t'(1);
                cnt <= '0;
            end
        end
    end

`ifdef PW_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT < 4096) ? 12 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_cnt;
    logic          in_hold;

    // Counts from entry into REQ; REL follows once TIMEOUT cycles were spent holding.
    assign in_hold = (state == ST_REQ) || (state == ST_GRANT);
    assign tmo_hit = in_hold && (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
            err_tmo <= 1'b0;
        end else begin
            tmo_cnt <= in_hold ? tmo_cnt + TW'(1) : '0;
            if (tmo_hit) err_tmo <= 1'b1;
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
    assign tmo_hit        = 1'b0;
    assign err_tmo        = 1'b0;
`endif

    // ---------------- IRQ fold ----------------
    logic [3:0] irq_fold, irq_q;

    always_comb begin
        irq_fold = '0;
        for (int j = 0; j < N_EP; j++)
            irq_fold[j % 4] = irq_fold[j % 4] | ep_irq[j];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_q <= '0;
        else        irq_q <= irq_fold;
    end

    assign pw.pw_irq = irq_q;

endmodule

// File: tb/tb_spi_dev_pw_arbiter.sv
// Self-checking bench for spi_dev_pw_arbiter with a 6-endpoint instance: routing
// counts, round-robin service order and byte streams, overflow, IRQ fold, reset.
module tb_spi_dev_pw_arbiter;

    localparam int N    = 6;
    localparam int MAXR = 256;
`ifdef PW_ARB_TIMEOUT_EN
    localparam int TMO     = 16;
    localparam int GNT_DLY = 0;
    localparam int STB_DLY = 0;
`else
    localparam int TMO     = 4096;
    localparam int GNT_DLY = 3;
    localparam int STB_DLY = 2;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_dev_pw_arbiter_if pw();

    logic [7:0]     ep_wdata;
    logic           ep_wcmd;
    logic [N-1:0]   ep_wstb, ep_end, ep_req, ep_gnt, ep_rstb, ep_irq;
    logic [8*N-1:0] ep_rdata;
    logic           err_ovf, err_tmo;

    spi_dev_pw_arbiter #(.N_EP(N), .MAX_RESP(MAXR), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pw       (pw),
        .ep_wdata (ep_wdata),
        .ep_wcmd  (ep_wcmd),
        .ep_wstb  (ep_wstb),
        .ep_end   (ep_end),
        .ep_req   (ep_req),
        .ep_gnt   (ep_gnt),
        .ep_rdata (ep_rdata),
        .ep_rstb  (ep_rstb),
        .ep_irq   (ep_irq),
        .err_ovf  (err_ovf),
        .err_tmo  (err_tmo)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse counters for the write-routing outputs.
    int wstb_cnt[N];
    int end_cnt[N];
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (ep_wstb[i]) wstb_cnt[i] <= wstb_cnt[i] + 1;
            if (ep_end[i])  end_cnt[i]  <= end_cnt[i] + 1;
        end
    end

    // Reference state
    int         exp_wstb[N];
    int         exp_end[N];
    int         model_rr  = 0;
    bit         model_ovf = 1'b0;
    logic [3:0] irq_model = 4'h0;
    logic [7:0] ep_q[N][$];
    int         ep_len[N];
    int         sent[N];

    task automatic wr_txn(input logic [7:0] cmd, input int nbytes);
        int idx;
        idx = int'(cmd) / 16;
        pw.pw_wdata = cmd;
        pw.pw_wcmd  = 1'b1;
        pw.pw_wstb  = 1'b1;
        #1;
        check("wdata_broadcast", {24'h0, ep_wdata}, {24'h0, cmd});
        tick();
        for (int k = 0; k < nbytes; k++) begin
            pw.pw_wcmd  = 1'b0;
            pw.pw_wdata = 8'($urandom);
            pw.pw_wstb  = 1'b1;
            tick();
            if ($urandom_range(0, 2) == 0) begin
                pw.pw_wstb = 1'b0;
                tick();
            end
        end
        pw.pw_wstb = 1'b0;
        pw.pw_wcmd = 1'b0;
        pw.pw_end  = 1'b1;
        tick();
        pw.pw_end = 1'b0;
        tick();
        if (idx < N) begin
            exp_wstb[idx] += nbytes + 1;
            exp_end[idx]  += 1;
        end
        for (int i = 0; i < N; i++) begin
            check($sformatf("wstb_cnt[%0d] cmd %02h", i, cmd), wstb_cnt[i], exp_wstb[i]);
            check($sformatf("end_cnt[%0d] cmd %02h", i, cmd), end_cnt[i], exp_end[i]);
        end
    endtask

    task automatic irq_step(input logic [N-1:0] v);
        logic [3:0] nxt;
        nxt = 4'h0;
        for (int j = 0; j < N; j++) nxt[j % 4] = nxt[j % 4] | v[j];
        ep_irq = v;
        #1;
        check("irq_before_edge", {28'h0, pw.pw_irq}, {28'h0, irq_model});
        tick();
        check($sformatf("irq_fold %02h", v), {28'h0, pw.pw_irq}, {28'h0, nxt});
        irq_model = nxt;
    endtask

    // All endpoints in mask request together and hold until served. Each sends
    // a random burst when granted; the wrapper side grants after a random delay.
    task automatic serve_round(input logic [N-1:0] mask, input int lo, input int hi);
        logic [7:0]   exp_data[$];
        logic [7:0]   got_data[$];
        int           exp_order[$];
        int           got_order[$];
        logic [N-1:0] pending;
        int           p, owner, prev_owner, cycles, c, n;
        bit           saw_low, found;

        for (int i = 0; i < N; i++) begin
            ep_q[i].delete();
            sent[i]   = 0;
            ep_len[i] = mask[i] ? int'($urandom_range(lo, hi)) : 0;
            for (int k = 0; k < ep_len[i]; k++) ep_q[i].push_back(8'($urandom));
        end

        pending = mask;
        p = model_rr;
        while (pending != '0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                c = (p + k) % N;
                if (!found && pending[c]) begin
                    found = 1'b1;
                    exp_order.push_back(c);
                    pending[c] = 1'b0;
                    p = (c + 1) % N;
                end
            end
        end
        model_rr = p;
        foreach (exp_order[o]) begin
            c = exp_order[o];
            n = (ep_len[c] < MAXR) ? ep_len[c] : MAXR;
            for (int k = 0; k < n; k++) exp_data.push_back(ep_q[c][k]);
            if (ep_len[c] > MAXR) model_ovf = 1'b1;
        end

        ep_req     = mask;
        ep_rstb    = '0;
        pw.pw_gnt  = 1'b0;
        prev_owner = -1;
        saw_low    = 1'b0;
        cycles     = 0;
        while (cycles < 5000) begin
            @(negedge clk);
            if (pw.pw_rstb) got_data.push_back(pw.pw_rdata);
            if (!pw.pw_req) saw_low = 1'b1;
            owner = -1;
            for (int i = 0; i < N; i++) if (ep_gnt[i]) owner = i;
            if (owner >= 0 && owner != prev_owner) begin
                if (got_order.size() > 0) check("req_gap_between_grants", {31'h0, saw_low}, 32'h1);
                got_order.push_back(owner);
                saw_low = 1'b0;
            end
            prev_owner = owner;
            if (ep_req == '0 && !pw.pw_req && !pw.pw_gnt) break;
            tick();
            cycles++;
            if (!pw.pw_req) pw.pw_gnt = 1'b0;
            else if ($urandom_range(0, GNT_DLY) == 0) pw.pw_gnt = 1'b1;
            ep_rstb = '0;
            for (int i = 0; i < N; i++) begin
                if (ep_gnt[i] && ep_req[i]) begin
                    if (sent[i] >= ep_len[i]) ep_req[i] = 1'b0;
                    else if ($urandom_range(0, STB_DLY) == 0) begin
                        ep_rdata[8*i +: 8] = ep_q[i][sent[i]];
                        ep_rstb[i] = 1'b1;
                        sent[i]++;
                    end
                end else if (!ep_gnt[i] && $urandom_range(0, 3) == 0) begin
                    ep_rdata[8*i +: 8] = 8'($urandom);
                    ep_rstb[i] = 1'b1;
                end
            end
        end
        ep_rstb = '0;
        tick();
        tick();

        check($sformatf("round %02h finished in budget", mask), {31'h0, cycles < 5000}, 32'h1);
        check($sformatf("round %02h grant count", mask), got_order.size(), exp_order.size());
        for (int o = 0; o < exp_order.size() && o < got_order.size(); o++)
            check($sformatf("round %02h grant #%0d", mask, o), got_order[o], exp_order[o]);
        check($sformatf("round %02h byte count", mask), got_data.size(), exp_data.size());
        for (int k = 0; k < exp_data.size() && k < got_data.size(); k++)
            if (got_data[k] !== exp_data[k])
                check($sformatf("round %02h byte #%0d", mask, k), {24'h0, got_data[k]}, {24'h0, exp_data[k]});
        check($sformatf("round %02h err_ovf", mask), {31'h0, err_ovf}, {31'h0, model_ovf});
    endtask

    initial begin
        int w, g, hi;

        pw.pw_wdata = '0; pw.pw_wcmd = 1'b0; pw.pw_wstb = 1'b0;
        pw.pw_end = 1'b0; pw.pw_gnt = 1'b0;
        ep_req = '0; ep_rdata = '0; ep_rstb = '0; ep_irq = '0;

        // Reset state
        tick(); tick();
        check("rst pw_req",  {31'h0, pw.pw_req},  32'h0);
        check("rst pw_rstb", {31'h0, pw.pw_rstb}, 32'h0);
        check("rst pw_irq",  {28'h0, pw.pw_irq},  32'h0);
        check("rst ep_gnt",  {26'h0, ep_gnt},     32'h0);
        check("rst ep_wstb", {26'h0, ep_wstb},    32'h0);
        check("rst ep_end",  {26'h0, ep_end},     32'h0);
        check("rst err_ovf", {31'h0, err_ovf},    32'h0);
        check("rst err_tmo", {31'h0, err_tmo},    32'h0);
        rst_n = 1'b1;
        tick();

        // Write routing: directed, reserved command, then random transactions
        wr_txn(8'h21, 3);
        wr_txn(8'hfe, 2);
        wr_txn(8'hff, 1);
        for (int t = 0; t < 20; t++) wr_txn(8'($urandom), int'($urandom_range(0, 4)));

        // IRQ fold
        irq_step(6'b100000);
        for (int t = 0; t < 8; t++) irq_step(N'($urandom));

        // Arbitration: directed pair, random rounds, overflow
        serve_round(6'b001010, 5, 5);
        for (int t = 0; t < 10; t++) serve_round(N'($urandom_range(1, (1 << N) - 1)), 0, 8);
`ifndef PW_ARB_TIMEOUT_EN
        serve_round(6'b000001, 300, 300);
`endif

        // Requester drops in REQ: one-cycle grant, zero bytes
        ep_req = 6'b010000;
        pw.pw_gnt = 1'b0;
        w = 0;
        while (!pw.pw_req && w < 20) begin tick(); w++; end
        check("dropreq reached REQ", {31'h0, pw.pw_req}, 32'h1);
        ep_req = '0;
        tick(); tick();
        check("dropreq waits for grant", {31'h0, pw.pw_req}, 32'h1);
        pw.pw_gnt = 1'b1;
        g = 0; w = 0;
        while (w < 20) begin
            tick(); w++;
            if (ep_gnt[4]) g++;
            if (!pw.pw_req) break;
        end
        check("dropreq grant cycles", g, 1);
        pw.pw_gnt = 1'b0;
        tick(); tick();
        model_rr = 5;

`ifdef PW_ARB_TIMEOUT_EN
        // Grant held past TIMEOUT is forced into release
        ep_req = 6'b000100;
        hi = 0; w = 0;
        while (w < 100) begin
            tick(); w++;
            if (pw.pw_req) begin hi++; pw.pw_gnt = 1'b1; end
            else if (hi > 0) break;
        end
        check("tmo hold cycles", hi, TMO);
        check("tmo err_tmo", {31'h0, err_tmo}, 32'h1);
        check("tmo ep_gnt dropped", {26'h0, ep_gnt}, 32'h0);
        ep_req = '0;
        pw.pw_gnt = 1'b0;
        tick(); tick();
        model_rr = 3;
        serve_round(6'b001001, 1, 4);
`else
        check("err_tmo absent", {31'h0, err_tmo}, 32'h0);
`endif

        // Asynchronous reset in the middle of a grant
        ep_irq = 6'b000001;
        ep_req = 6'b000010;
        w = 0;
        while (!ep_gnt[1] && w < 50) begin
            tick(); w++;
            if (pw.pw_req) pw.pw_gnt = 1'b1;
        end
        check("arst grant reached", {31'h0, ep_gnt[1]}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst pw_req", {31'h0, pw.pw_req}, 32'h0);
        check("arst ep_gnt", {26'h0, ep_gnt},    32'h0);
        check("arst err_ovf", {31'h0, err_ovf},  32'h0);
        check("arst pw_irq", {28'h0, pw.pw_irq}, 32'h0);
        ep_req = '0; ep_irq = '0; pw.pw_gnt = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        check("post-reset pw_req", {31'h0, pw.pw_req}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
